// File: rtl/ped_button_conditioner_pkg.sv
// Shared traffic-light definitions: the pedestrian-button FSM encoding and the
// missed-press counter width, used by this block and by Traffic_light_controller.
package ped_button_conditioner_pkg;

  localparam int unsigned MISSED_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } ped_btn_state_e;

endpackage

// File: rtl/ped_button_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ped_button_conditioner.sv
// Pedestrian button conditioner: synchronizes and debounces the raw button,
// then holds a request level until the controller acknowledges it.
module ped_button_conditioner
  import ped_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    button_raw,
  input  logic                    req_ack,
  output logic                    button_pressed,
  output logic                    press_pulse,
  output logic                    button_stable,
  output logic [MISSED_CNT_W-1:0] missed_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  ped_btn_state_e   state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             sync;
  logic             accept;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button_raw),
    .q     (sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_next = DEB_PRESS;
          cnt_next   = '0;
        end
      end
      DEB_PRESS: begin
        if (!sync) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_next = DEB_RELEASE;
          cnt_next   = '0;
        end
      end
      DEB_RELEASE: begin
        // A re-press here is only release bounce, so it never raises accept.
        if (sync) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    button_stable = (state == PRESSED) || (state == DEB_RELEASE);
  end

  // A new press wins over a same-edge acknowledge and is then not counted as missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse    <= 1'b0;
      button_pressed <= 1'b0;
      missed_cnt     <= '0;
    end else begin
      press_pulse <= accept;
      if (accept) begin
        button_pressed <= 1'b1;
        if (button_pressed && !req_ack && (missed_cnt != '1)) begin
          missed_cnt <= missed_cnt + 1'b1;
        end
      end else if (req_ack) begin
        button_pressed <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ped_button_conditioner.md
PED_BUTTON_CONDITIONER -- requirements
Module: ped_button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of consecutive stable synchronized samples needed to accept a press or release edge; legal range is 2 or greater.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port button_raw, input, 1 bit: the asynchronous, bouncy pedestrian button (1 = pressed).
REQ-005 The block SHALL have port req_ack, input, 1 bit: a single-cycle acknowledge from the traffic light controller consuming the pending request.
REQ-006 The block SHALL have port button_pressed, output, 1 bit: the level request to the controller, held until acknowledged.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: a one-cycle strobe per accepted press.
REQ-008 The block SHALL have port button_stable, output, 1 bit: the debounced button level.
REQ-009 The block SHALL have port missed_cnt, output, 4 bits: a saturating count of presses merged into an already-pending request.

Function
REQ-010 button_raw SHALL pass through a 2-flop synchronizer; only the second flop output (sync) is used by the FSM.
REQ-011 The FSM SHALL have states IDLE, DEB_PRESS, PRESSED and DEB_RELEASE, plus a debounce counter cnt of width clog2(DEBOUNCE_CYCLES).
REQ-012 In IDLE, sync=1 SHALL move the FSM to DEB_PRESS with cnt=0; otherwise it remains in IDLE.
REQ-013 In DEB_PRESS, sync=0 SHALL return the FSM to IDLE; sync=1 with cnt==DEBOUNCE_CYCLES-1 SHALL move it to PRESSED; otherwise cnt SHALL increment.
REQ-014 In PRESSED, sync=0 SHALL move the FSM to DEB_RELEASE with cnt=0.
REQ-015 In DEB_RELEASE, sync=1 SHALL return the FSM to PRESSED without generating a new press; sync=0 with cnt==DEBOUNCE_CYCLES-1 SHALL move it to IDLE; otherwise cnt SHALL increment.
REQ-016 Latency: press_pulse SHALL be high for exactly the one cycle following the DEB_PRESS-to-PRESSED edge, i.e. after rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples button_raw=1.
REQ-017 button_stable SHALL be 1 in PRESSED and DEB_RELEASE, and 0 in IDLE and DEB_PRESS.
REQ-018 An accepted press SHALL set the request latch, driving button_pressed=1 from the same edge that raises press_pulse.
REQ-019 req_ack=1 with no simultaneous press SHALL clear button_pressed on the next edge.
REQ-020 When req_ack and an accepted press occur on the same edge, the set SHALL win: button_pressed stays 1 and missed_cnt does not change.
REQ-021 An accepted press while button_pressed=1 and req_ack=0 SHALL increment missed_cnt, saturating at 15.
REQ-022 req_ack while button_pressed=0 SHALL be ignored.
REQ-023 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no press_pulse.

Reset
REQ-024 Asserting rst_n=0 at any time, including mid-debounce, SHALL immediately force: FSM=IDLE, cnt=0, synchronizer flops=0, button_pressed=0, press_pulse=0, button_stable=0, missed_cnt=0.
REQ-025 After release of rst_n, a button_raw that is already held high SHALL be debounced as a fresh press.

Structure
REQ-026 The FSM state encoding and the missed_cnt width constant SHALL reside in a shared traffic-light package used by this block and by Traffic_light_controller.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff; everything else SHALL be flat.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: button_raw 0->1 and held -> press_pulse high for one cycle after edge 7, button_pressed=1 and button_stable=1 from that edge.
REQ-029 Bounce: button_raw toggled 1,0,1,0 with 2-cycle high glitches, then held 0 -> no press_pulse, button_pressed stays 0.
REQ-030 Ack handshake: after an accepted press, req_ack pulsed for 1 cycle -> button_pressed=0 on the next edge; a release bounce of fewer than 4 samples in DEB_RELEASE -> no new press_pulse.
REQ-031 Merge and saturation: 17 accepted presses with no req_ack -> button_pressed stays 1 and missed_cnt=15.
REQ-032 Simultaneous events: req_ack on the same edge as an accepted press -> button_pressed remains 1 and missed_cnt is unchanged.
REQ-033 Reset mid-operation: rst_n pulsed low in DEB_PRESS with cnt=2 -> all outputs 0 asynchronously; with button_raw still high, press_pulse occurs 7 edges after reset release.
